uart_cmd_dispatch: RTL and testbench



---
 rtl/uart_cmd_dispatch.sv | 175 +++++++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatch.sv
// UART byte command dispatcher: colour/brightness control, line load and frame fill
// into a ready-handshaked frame-buffer write port, with inter-byte timeout.
module uart_cmd_dispatch #(
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int BRIGHTNESS_BITS = 6,
    parameter int LITTLE_ENDIAN   = 1,
    parameter int TIMEOUT_CYCLES  = 4095,
    localparam int ROW_W  = $clog2(PIXEL_HEIGHT),
    localparam int COL_W  = $clog2(PIXEL_WIDTH * BYTES_PER_PIXEL),
    localparam int ADDR_W = ROW_W + COL_W
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       ram_ready,
    output logic [2:0]                 rgb_enable,
    output logic [BRIGHTNESS_BITS-1:0] brightness_enable,
    output logic [7:0]                 ram_data_out,
    output logic [ADDR_W-1:0]          ram_address,
    output logic                       ram_write_enable,
    output logic                       busy,
    output logic [7:0]                 cmd_count,
    output logic                       timeout_err,
    output logic                       overrun_err
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [COL_W-1:0]  COL_LAST  = '1;
    localparam logic [COL_W-1:0]  COL_FLIP  = (LITTLE_ENDIAN != 0) ? '0 : COL_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        DATA,
        FILL_VAL,
        FILL
    } state_t;

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [7:0]         fill_val;
    logic               fill_first;
    logic [TCNT_W-1:0]  idle_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            rgb_enable        <= 3'b111;
            brightness_enable <= '1;
            ram_data_out      <= '0;
            ram_address       <= '0;
            ram_write_enable  <= 1'b0;
            cmd_count         <= '0;
            timeout_err       <= 1'b0;
            overrun_err       <= 1'b0;
            row               <= '0;
            col               <= '0;
            fill_val          <= '0;
            fill_first        <= 1'b0;
            idle_cnt          <= '0;
        end else begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;

            // An accepted write retires unless a state below issues the next one.
            if (ram_write_enable && ram_ready)
                ram_write_enable <= 1'b0;

            if (state == ROW || state == DATA || state == FILL_VAL) begin
                if (rx_valid) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == TCNT_LAST) begin
                    idle_cnt    <= '0;
                    state       <= IDLE;
                    timeout_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            "R": rgb_enable[0] <= 1'b1;
                            "r": rgb_enable[0] <= 1'b0;
                            "G": rgb_enable[1] <= 1'b1;
                            "g": rgb_enable[1] <= 1'b0;
                            "B": rgb_enable[2] <= 1'b1;
                            "b": rgb_enable[2] <= 1'b0;
                            "0": brightness_enable <= '0;
                            "9": brightness_enable <= '1;
                            "L": state <= ROW;
                            "F": state <= FILL_VAL;
                            "1", "2", "3", "4", "5", "6", "7", "8": begin
                                // Digit k addresses bit-plane BRIGHTNESS_BITS-k; larger k falls off the end.
                                for (int i = 0; i < BRIGHTNESS_BITS; i++) begin
                                    if (int'(rx_data[3:0]) == BRIGHTNESS_BITS - i)
                                        brightness_enable[i] <= ~brightness_enable[i];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ROW: begin
                    if (rx_valid) begin
                        row   <= rx_data[ROW_W-1:0];
                        col   <= '0;
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (rx_valid) begin
                        if (ram_write_enable && !ram_ready) begin
                            overrun_err <= 1'b1;
                        end else begin
                            ram_data_out     <= rx_data;
                            ram_address      <= {row, col ^ COL_FLIP};
                            ram_write_enable <= 1'b1;
                            col              <= col + 1'b1;
                            if (col == COL_LAST) begin
                                state     <= IDLE;
                                cmd_count <= cmd_count + 1'b1;
                            end
                        end
                    end
                end

                FILL_VAL: begin
                    if (rx_valid) begin
                        fill_val   <= rx_data;
                        fill_first <= 1'b1;
                        state      <= FILL;
                    end
                end

                FILL: begin
                    if (rx_valid)
                        overrun_err <= 1'b1;
                    // fill_first waits out any line write still pending from before.
                    if (!ram_write_enable || ram_ready) begin
                        if (fill_first) begin
                            fill_first       <= 1'b0;
                            ram_address      <= '0;
                            ram_data_out     <= fill_val;
                            ram_write_enable <= 1'b1;
                        end else if (ram_address == ADDR_LAST) begin
                            state     <= IDLE;
                            cmd_count <= cmd_count + 1'b1;
                        end else begin
                            ram_address      <= ram_address + 1'b1;
                            ram_write_enable <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed bench for uart_cmd_dispatch: colour/brightness decode, line load,
// timeout, frame fill with stalling RAM, overrun and asynchronous reset.
module tb_uart_cmd_dispatch;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ram_ready;

    logic [2:0]  rgb_enable, be_rgb;
    logic [5:0]  brightness_enable, be_bright;
    logic [7:0]  ram_data_out, be_data;
    logic [11:0] ram_address, be_addr;
    logic        ram_write_enable, be_wen;
    logic        busy, be_busy;
    logic [7:0]  cmd_count, be_cmd;
    logic        timeout_err, be_tmo;
    logic        overrun_err, be_ovr;

    int checks = 0;
    int failures = 0;

    logic [11:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          hold_err = 0;
    logic        prev_hold = 1'b0;
    logic [11:0] prev_addr;
    logic [7:0]  prev_data;

    always #5 clk_in = ~clk_in;

    uart_cmd_dispatch dut (
        .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_ready(ram_ready), .rgb_enable(rgb_enable), .brightness_enable(brightness_enable),
        .ram_data_out(ram_data_out), .ram_address(ram_address),
        .ram_write_enable(ram_write_enable), .busy(busy), .cmd_count(cmd_count),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    uart_cmd_dispatch #(.LITTLE_ENDIAN(0)) dut_be (
        .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_ready(ram_ready), .rgb_enable(be_rgb), .brightness_enable(be_bright),
        .ram_data_out(be_data), .ram_address(be_addr),
        .ram_write_enable(be_wen), .busy(be_busy), .cmd_count(be_cmd),
        .timeout_err(be_tmo), .overrun_err(be_ovr)
    );

    // Write log of accepted transfers plus a stability check while stalled.
    always @(posedge clk_in) begin
        if (ram_write_enable && ram_ready) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_data_out);
        end
        if (prev_hold && (!ram_write_enable || ram_address != prev_addr || ram_data_out != prev_data))
            hold_err++;
        prev_hold = ram_write_enable && !ram_ready && !reset;
        prev_addr = ram_address;
        prev_data = ram_data_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        int n;
        int errs;

        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        ram_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_rgb", 32'(rgb_enable), 32'h7);
        check("rst_bright", 32'(brightness_enable), 32'h3f);
        check("rst_wen", 32'(ram_write_enable), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd", 32'(cmd_count), 32'h0);
        reset = 1'b0;

        // Colour and brightness decode
        send_byte("r");
        send_byte("g");
        send_byte("6");
        check("rgb_rg", 32'(rgb_enable), 32'h4);
        check("bright_6", 32'(brightness_enable), 32'h3e);
        send_byte("7");
        check("bright_7_ignored", 32'(brightness_enable), 32'h3e);
        send_byte("0");
        check("bright_0", 32'(brightness_enable), 32'h00);
        send_byte("9");
        check("bright_9", 32'(brightness_enable), 32'h3f);
        send_byte("1");
        check("bright_1", 32'(brightness_enable), 32'h1f);

        // Line load, row 5, full 128 columns
        clear_log();
        send_byte("L");
        check("busy_row", 32'(busy), 32'h1);
        send_byte(8'h05);
        send_byte(8'h00);
        check("l_first_addr", 32'(ram_address), 32'h280);
        check("l_first_wen", 32'(ram_write_enable), 32'h1);
        check("be_first_addr", 32'(be_addr), 32'h281);
        for (int k = 1; k < 128; k++) send_byte(8'(k));
        repeat (2) @(negedge clk_in);
        check("l_count", 32'(wr_addr.size()), 32'd128);
        errs = 0;
        for (int k = 0; k < wr_addr.size(); k++)
            if (wr_addr[k] != 12'(12'h280 + k) || wr_data[k] != 8'(k)) errs++;
        check("l_seq_err", 32'(errs), 32'd0);
        check("l_cmd", 32'(cmd_count), 32'd1);
        check("l_idle", 32'(busy), 32'h0);
        check("l_wen_off", 32'(ram_write_enable), 32'h0);

        // Timeout after 10 bytes of row 3
        clear_log();
        send_byte("L");
        send_byte(8'h03);
        for (int k = 0; k < 10; k++) send_byte(8'(8'h40 + k));
        n = 0;
        while (n < 5000 && !timeout_err) begin
            @(negedge clk_in);
            n++;
        end
        check("tmo_latency", 32'(n), 32'd4095);
        @(negedge clk_in);
        check("tmo_pulse", 32'(timeout_err), 32'h0);
        check("tmo_idle", 32'(busy), 32'h0);
        check("tmo_writes", 32'(wr_addr.size()), 32'd10);
        check("tmo_cmd", 32'(cmd_count), 32'd1);
        send_byte("R");
        check("tmo_then_R", 32'(rgb_enable), 32'h5);

        // Frame fill with stalling RAM and a dropped byte mid-fill
        clear_log();
        hold_err = 0;
        send_byte("F");
        send_byte(8'hAA);
        n = 0;
        while (n < 20000 && busy) begin
            @(negedge clk_in);
            if (n == 1001) begin
                rx_valid = 1'b0;
                check("fill_overrun", 32'(overrun_err), 32'h1);
            end
            ram_ready = (n % 2 == 0);
            if (n == 1000) begin
                rx_data  = "b";
                rx_valid = 1'b1;
            end
            n++;
        end
        rx_valid  = 1'b0;
        ram_ready = 1'b1;
        check("fill_done", 32'(busy), 32'h0);
        check("fill_count", 32'(wr_addr.size()), 32'd4096);
        errs = 0;
        for (int k = 0; k < wr_addr.size(); k++)
            if (wr_addr[k] != 12'(k) || wr_data[k] != 8'hAA) errs++;
        check("fill_seq_err", 32'(errs), 32'd0);
        check("fill_hold_err", 32'(hold_err), 32'd0);
        check("fill_cmd", 32'(cmd_count), 32'd2);
        check("fill_no_decode", 32'(rgb_enable), 32'h5);

        // Overrun on a stalled line write
        clear_log();
        ram_ready = 1'b0;
        send_byte("L");
        send_byte(8'h01);
        send_byte(8'h11);
        check("ovr_first_addr", 32'(ram_address), 32'h080);
        send_byte(8'h22);
        check("ovr_pulse", 32'(overrun_err), 32'h1);
        check("ovr_hold_addr", 32'(ram_address), 32'h080);
        check("ovr_hold_data", 32'(ram_data_out), 32'h11);
        check("ovr_hold_wen", 32'(ram_write_enable), 32'h1);
        @(negedge clk_in);
        ram_ready = 1'b1;
        @(negedge clk_in);
        ram_ready = 1'b0;
        check("ovr_accept_cnt", 32'(wr_addr.size()), 32'd1);
        check("ovr_wen_off", 32'(ram_write_enable), 32'h0);
        send_byte(8'h33);
        check("ovr_next_col", 32'(ram_address), 32'h081);
        check("ovr_next_data", 32'(ram_data_out), 32'h33);

        // Asynchronous reset with a write still pending
        @(negedge clk_in);
        #1 reset = 1'b1;
        #1;
        check("arst_wen", 32'(ram_write_enable), 32'h0);
        check("arst_addr", 32'(ram_address), 32'h0);
        check("arst_data", 32'(ram_data_out), 32'h0);
        check("arst_rgb", 32'(rgb_enable), 32'h7);
        check("arst_bright", 32'(brightness_enable), 32'h3f);
        check("arst_cmd", 32'(cmd_count), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk_in);
        reset     = 1'b0;
        ram_ready = 1'b1;
        repeat (5) @(negedge clk_in);
        check("arst_no_write", 32'(wr_addr.size()), 32'd1);
        send_byte("L");
        send_byte(8'h02);
        send_byte(8'h44);
        check("post_rst_addr", 32'(ram_address), 32'h100);
        check("post_rst_data", 32'(ram_data_out), 32'h44);
        check("post_rst_busy", 32'(busy), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
